execute_stage_mdu: RTL and testbench
====================================

# execute_stage_mdu

Parametrised execute stage for the 5-stage RISC-V pipeline: it sits between the ID/EX register and the memory stage. It adds operand forwarding, full RV32I branch/jump resolution, a 10-op ALU and an iterative multiply/divide unit (MDU) that stalls upstream while busy. It owns the EX/MEM pipeline register.

## Interface
- XLEN, 32: datapath width; must be a power of two and at least 8.
- RA_W, 5: register-address width.
- MDU_EN, 1: 0 removes the MDU; md_e is then ignored and treated as an ALU op.

Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- valid_e  in  1  E-stage holds a real instruction
- reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e, md_e  in  1 each  decoded controls
- result_src_e  in  2  writeback select, passed through
- alu_control_e  in  4  ALU op
- branch_op_e  in  3  funct3 of the branch
- md_op_e  in  2  MDU op: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
- forward_a_e, forward_b_e  in  2  operand select: 00 RD, 01 result_w, 10 alu_result_m, 11 RD
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w  in  XLEN each  operands
- rd_e  in  RA_W  destination register
- pc_src_e  out  1  redirect fetch
- pc_target_e  out  XLEN  redirect address
- busy_e  out  1  stall request to the hazard unit
- valid_m, reg_write_m, mem_write_m  out  1 each  EX/MEM controls
- result_src_m  out  2  EX/MEM writeback select
- rd_m  out  RA_W  EX/MEM destination register
- alu_result_m, write_data_m, pc_plus4_m  out  XLEN each  EX/MEM data

## Operation
- **Operand selection.** srcA is the forward_a_e-selected value. fwdB is the forward_b_e-selected value. srcB is imm_ext_e when alu_src_e=1, otherwise fwdB. write_data_m captures fwdB.
- **ALU ops:**
  - 0 add, 1 sub, 2 and, 3 or, 4 xor
  - 5 slt (signed), 6 sltu
  - 7 sll, 8 srl, 9 sra; shift amount is srcB[log2(XLEN)-1:0]
  - any other code gives a result of 0
- **Branch conditions** (branch_op_e): 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu, computed on srcA vs fwdB. Codes 010 and 011 are never taken.
- **Redirect.**
  - pc_src_e = valid_e & (jump_e | jalr_e | (branch_e & cond)).
  - pc_target_e = jalr_e ? (srcA+imm_ext_e) & ~1 : pc_e+imm_ext_e.
- **MDU FSM states:** IDLE, BUSY, DONE.
  - IDLE -> BUSY when valid_e & md_e. On that edge the FSM latches srcA, srcB, md_op_e, rd_e and the controls, then loads count = XLEN-1.
  - BUSY: one shift-add (MUL/MULHU) or restoring-subtract (DIVU/REMU) step per cycle; count decrements. BUSY -> DONE when count = 0.
  - DONE -> IDLE unconditionally. The still-held md instruction is not restarted.
- **MDU results.**
  - MUL: low XLEN bits of the product. MULHU: high XLEN bits of the unsigned product.
  - Divide by zero: DIVU returns all ones; REMU returns the dividend.
- **EX/MEM register.**
  - Captures on every edge when busy_e=0.
  - When busy_e=1 it captures a bubble: valid_m, reg_write_m and mem_write_m are 0, other fields don't-care.
  - An invalid instruction (valid_e=0) also yields valid_m=0 with all controls 0.
  - In DONE, alu_result_m captures the MDU result; the other fields come from the latched copies.

## Timing
- busy_e = (IDLE & valid_e & md_e & MDU_EN) | BUSY; it is combinational and is 0 in DONE.
- ALU ops: 1-cycle latency to the *_m outputs.
- MDU ops: busy_e is high for XLEN+1 consecutive cycles (33 at XLEN=32). The result appears on alu_result_m XLEN+2 edges after the op is first presented.
- Upstream holds the E-stage inputs while busy_e=1. Operand changes during BUSY, e.g. from forwarding, have no effect because the operands are latched.
- pc_src_e and pc_target_e are combinational. pc_src_e is forced to 0 while rst=0.
- Reset (asynchronous, any state including mid-BUSY): FSM goes to IDLE, count to 0, and every *_m output to 0. busy_e drops immediately and pc_src_e is 0.
- Forwarding from alu_result_m uses the registered output, i.e. the previous instruction's result.

## Structure
- Package ex_pkg holds: ALU op constants, branch funct3 constants, MDU op constants, forward-select constants, and the MDU state enum.
- Sub-module mdu_iterative holds the FSM, counter, and accumulator/remainder registers, with a start/busy/done handshake.
- The ALU, branch compare, forwarding muxes and EX/MEM register are inline in execute_stage_mdu.

## Test plan
- **ADD with both forwards.** Stimulus: forward_a_e=10 with alu_result_m=5, forward_b_e=01 with result_w=7, alu_control_e=0. Required: alu_result_m=12 after one edge, valid_m=1.
- **BLT and BGEU.** Stimulus: BLT with srcA=-1, fwdB=1, pc_e=0x100, imm=0x20. Required: pc_src_e=1, pc_target_e=0x120. Same operands with BGEU (0xFFFFFFFF ≥ 1) is also taken. JALR with srcA=0x203, imm=0 gives target 0x202.
- **MUL.** Stimulus: MUL 0x10000 × 0x10000. Required: busy_e high for 33 cycles, bubbles with valid_m=0 on *_m meanwhile, then alu_result_m=0. MULHU on the same operands gives 1.
- **Divide by zero.** Stimulus: DIVU 100/0 and REMU 100/0. Required: 0xFFFFFFFF and 100. DIVU 100/7 gives 14; REMU 100/7 gives 2.
- **Reset mid-operation.** Stimulus: assert rst at cycle 10 of a DIVU. Required: busy_e=0 and all *_m=0 immediately. After release, a new ADD completes normally.
- **Bubbles and operand latching.** Stimulus: valid_e=0 with reg_write_e=1. Required: reg_write_m=0. Changing result_w during BUSY does not alter the MDU result.

Source files
------------

// File: rtl/execute_stage_mdu_pkg.sv
// ex_pkg: shared opcodes, forward selects and MDU state encoding for the execute stage
package ex_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [2:0] BR_EQ = 3'b000;
  localparam logic [2:0] BR_NE = 3'b001;
  localparam logic [2:0] BR_LT = 3'b100;
  localparam logic [2:0] BR_GE = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;
  localparam logic [1:0] MD_MUL = 2'b00;
  localparam logic [1:0] MD_MULHU = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;
  localparam logic [1:0] MD_REMU = 2'b11;
  localparam logic [1:0] FWD_RD = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_t;
endpackage

// File: rtl/execute_stage_mdu_if.sv
// execute_stage_mdu_if: E-stage inputs (master drives) and redirect/stall/EX-MEM outputs (slave drives)
interface execute_stage_mdu_if #(parameter int XLEN = 32, parameter int RA_W = 5);
  logic valid_e, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e, md_e;
  logic [1:0] result_src_e, md_op_e, forward_a_e, forward_b_e;
  logic [3:0] alu_control_e;
  logic [2:0] branch_op_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w;
  logic [RA_W-1:0] rd_e;
  logic pc_src_e, busy_e;
  logic [XLEN-1:0] pc_target_e;
  logic valid_m, reg_write_m, mem_write_m;
  logic [1:0] result_src_m;
  logic [RA_W-1:0] rd_m;
  logic [XLEN-1:0] alu_result_m, write_data_m, pc_plus4_m;
  modport master (
    output valid_e, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e, md_e,
    output result_src_e, md_op_e, forward_a_e, forward_b_e, alu_control_e, branch_op_e,
    output rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w, rd_e,
    input pc_src_e, busy_e, pc_target_e, valid_m, reg_write_m, mem_write_m,
    input result_src_m, rd_m, alu_result_m, write_data_m, pc_plus4_m
  );
  modport slave (
    input valid_e, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e, md_e,
    input result_src_e, md_op_e, forward_a_e, forward_b_e, alu_control_e, branch_op_e,
    input rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w, rd_e,
    output pc_src_e, busy_e, pc_target_e, valid_m, reg_write_m, mem_write_m,
    output result_src_m, rd_m, alu_result_m, write_data_m, pc_plus4_m
  );
endinterface

// File: rtl/execute_stage_mdu_mdu.sv
// mdu_iterative: one-bit-per-cycle shift-add multiplier / restoring divider
// ports: start_i/op_i/a_i/b_i request; load_o accept edge, busy_o stall, done_o result valid, result_o
module mdu_iterative import ex_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            load_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  mdu_state_t state_q, state_d;
  logic [CW-1:0] count_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, hi_d, lo_d;
  logic [1:0] op_q;
  logic [XLEN:0] sum, shl, diff;
  // hi:lo is the product (hi grows, multiplier shifts out of lo) or remainder:quotient
  always_comb begin
    state_d = state_q == MDU_IDLE ? (start_i ? MDU_BUSY : MDU_IDLE) :
              state_q == MDU_BUSY ? (count_q == '0 ? MDU_DONE : MDU_BUSY) : MDU_IDLE;
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shl = {hi_q, lo_q[XLEN-1]};
    diff = shl - {1'b0, b_q};
    hi_d = op_q[1] ? (diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    lo_d = op_q[1] ? {lo_q[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo_q[XLEN-1:1]};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MDU_IDLE;
      count_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      op_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_o) begin
        count_q <= CW'(XLEN - 1);
        hi_q <= '0;
        lo_q <= a_i;
        b_q <= b_i;
        op_q <= op_i;
      end else if (state_q == MDU_BUSY) begin
        count_q <= count_q - CW'(1);
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end
  // a zero divisor naturally leaves quotient all ones and remainder equal to the dividend
  assign load_o = (state_q == MDU_IDLE) && start_i;
  assign busy_o = load_o || (state_q == MDU_BUSY);
  assign done_o = state_q == MDU_DONE;
  assign result_o = op_q[0] ? hi_q : lo_q;
endmodule

// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: RV32 execute stage with forwarding, branch resolution, ALU, iterative MDU and EX/MEM register
// ports: clk, rst (async active-low), bus (slave side of execute_stage_mdu_if)
module execute_stage_mdu import ex_pkg::*; #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter bit MDU_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  execute_stage_mdu_if.slave bus
);
  localparam int SH = $clog2(XLEN);
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, md_res, hold_wd_q, hold_pc4_q;
  logic cond, start, md_load, md_busy, md_done, hold_rw_q, hold_mw_q;
  logic [1:0] hold_rs_q;
  logic [RA_W-1:0] hold_rd_q;
  always_comb begin
    src_a = bus.forward_a_e == FWD_W ? bus.result_w : bus.forward_a_e == FWD_M ? bus.alu_result_m : bus.rd1_e;
    fwd_b = bus.forward_b_e == FWD_W ? bus.result_w : bus.forward_b_e == FWD_M ? bus.alu_result_m : bus.rd2_e;
    src_b = bus.alu_src_e ? bus.imm_ext_e : fwd_b;
  end
  always_comb begin
    alu_res = '0;
    case (bus.alu_control_e)
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR: alu_res = src_a | src_b;
      ALU_XOR: alu_res = src_a ^ src_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL: alu_res = src_a << src_b[SH-1:0];
      ALU_SRL: alu_res = src_a >> src_b[SH-1:0];
      ALU_SRA: alu_res = $unsigned($signed(src_a) >>> src_b[SH-1:0]);
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    cond = 1'b0;
    case (bus.branch_op_e)
      BR_EQ: cond = src_a == fwd_b;
      BR_NE: cond = src_a != fwd_b;
      BR_LT: cond = $signed(src_a) < $signed(fwd_b);
      BR_GE: cond = $signed(src_a) >= $signed(fwd_b);
      BR_LTU: cond = src_a < fwd_b;
      BR_GEU: cond = src_a >= fwd_b;
      default: cond = 1'b0;
    endcase
  end
  assign bus.pc_src_e = rst && bus.valid_e && (bus.jump_e || bus.jalr_e || (bus.branch_e && cond));
  assign bus.pc_target_e = bus.jalr_e ? (src_a + bus.imm_ext_e) & {{(XLEN-1){1'b1}}, 1'b0} : bus.pc_e + bus.imm_ext_e;
  // gating with rst lets busy_e fall as soon as reset asserts even if the md op is still presented
  assign start = MDU_EN && rst && bus.valid_e && bus.md_e;
  generate
    if (MDU_EN) begin : g_mdu
      mdu_iterative #(.XLEN(XLEN)) u_mdu (
        .clk(clk), .rst(rst), .start_i(start), .op_i(bus.md_op_e), .a_i(src_a), .b_i(src_b),
        .load_o(md_load), .busy_o(md_busy), .done_o(md_done), .result_o(md_res)
      );
    end else begin : g_no_mdu
      assign md_load = 1'b0;
      assign md_busy = 1'b0;
      assign md_done = 1'b0;
      assign md_res = '0;
    end
  endgenerate
  assign bus.busy_e = md_busy;
  // md instruction's EX/MEM fields, frozen at start so forwarding changes while busy are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_rd_q <= '0;
      hold_rw_q <= 1'b0;
      hold_mw_q <= 1'b0;
      hold_rs_q <= '0;
      hold_wd_q <= '0;
      hold_pc4_q <= '0;
    end else if (md_load) begin
      hold_rd_q <= bus.rd_e;
      hold_rw_q <= bus.reg_write_e;
      hold_mw_q <= bus.mem_write_e;
      hold_rs_q <= bus.result_src_e;
      hold_wd_q <= fwd_b;
      hold_pc4_q <= bus.pc_plus4_e;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.valid_m <= 1'b0;
      bus.reg_write_m <= 1'b0;
      bus.mem_write_m <= 1'b0;
      bus.result_src_m <= '0;
      bus.rd_m <= '0;
      bus.alu_result_m <= '0;
      bus.write_data_m <= '0;
      bus.pc_plus4_m <= '0;
    end else if (bus.busy_e) begin
      bus.valid_m <= 1'b0;
      bus.reg_write_m <= 1'b0;
      bus.mem_write_m <= 1'b0;
    end else if (md_done) begin
      bus.valid_m <= 1'b1;
      bus.reg_write_m <= hold_rw_q;
      bus.mem_write_m <= hold_mw_q;
      bus.result_src_m <= hold_rs_q;
      bus.rd_m <= hold_rd_q;
      bus.alu_result_m <= md_res;
      bus.write_data_m <= hold_wd_q;
      bus.pc_plus4_m <= hold_pc4_q;
    end else begin
      bus.valid_m <= bus.valid_e;
      bus.reg_write_m <= bus.valid_e && bus.reg_write_e;
      bus.mem_write_m <= bus.valid_e && bus.mem_write_e;
      bus.result_src_m <= bus.valid_e ? bus.result_src_e : '0;
      bus.rd_m <= bus.rd_e;
      bus.alu_result_m <= alu_res;
      bus.write_data_m <= fwd_b;
      bus.pc_plus4_m <= bus.pc_plus4_e;
    end
  end
endmodule

// File: tb/tb_execute_stage_mdu.sv
// tb_execute_stage_mdu: vector table, hand sequences and random ops against a behavioural model
module tb_execute_stage_mdu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  execute_stage_mdu_if #(.XLEN(32), .RA_W(5)) bus ();
  execute_stage_mdu #(.XLEN(32), .RA_W(5), .MDU_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [3:0] op;
    logic [31:0] a, b, imm;
    logic src;
    logic [31:0] exp;
    string nm;
  } vec_t;
  vec_t tv[12];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] prev_m;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    {bus.valid_e, bus.reg_write_e, bus.mem_write_e, bus.alu_src_e, bus.branch_e, bus.jump_e, bus.jalr_e, bus.md_e} = '0;
    {bus.result_src_e, bus.md_op_e, bus.forward_a_e, bus.forward_b_e} = '0;
    bus.alu_control_e = '0;
    bus.branch_op_e = '0;
    {bus.rd1_e, bus.rd2_e, bus.imm_ext_e, bus.pc_e, bus.pc_plus4_e, bus.result_w} = '0;
    bus.rd_e = '0;
  endtask
  function automatic logic [31:0] sel(input logic [1:0] f, input logic [31:0] rd, w, m);
    return f == 2'd1 ? w : f == 2'd2 ? m : rd;
  endfunction
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6: return (a < b) ? 32'd1 : 32'd0;
      7: return a << (b % 32);
      8: return a >> (b % 32);
      9: return int'(a) >>> (b % 32);
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [31:0] a, b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      0: return p[31:0];
      1: return p[63:32];
      2: return b == 0 ? 32'hFFFF_FFFF : a / b;
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  // presents an md op, counts stall cycles, checks bubbles and the final result
  task automatic run_md(input string nm, input logic [1:0] op, input logic [31:0] a, b, exp, input bit poke_w);
    int cnt;
    bit bub;
    @(negedge clk);
    idle_in();
    bus.valid_e = 1'b1;
    bus.md_e = 1'b1;
    bus.reg_write_e = 1'b1;
    bus.md_op_e = op;
    bus.rd_e = 5'd9;
    bus.forward_a_e = poke_w ? 2'b01 : 2'b00;
    bus.rd1_e = a;
    bus.result_w = a;
    bus.rd2_e = b;
    #1;
    cnt = 0;
    bub = 1'b1;
    while (bus.busy_e && cnt < 100) begin
      cnt++;
      tick();
      if (bus.valid_m !== 1'b0) bub = 1'b0;
      if (poke_w) bus.result_w = $urandom;
    end
    chk({nm, " busy cycles"}, cnt, 33);
    chk({nm, " bubbles"}, {31'd0, bub}, 32'd1);
    tick();
    chk({nm, " result"}, bus.alu_result_m, exp);
    chk({nm, " valid_m"}, {31'd0, bus.valid_m}, 32'd1);
    chk({nm, " rd_m"}, {27'd0, bus.rd_m}, 32'd9);
    bus.md_e = 1'b0;
    bus.valid_e = 1'b0;
    prev_m = exp;
  endtask
  initial begin
    logic [3:0] op;
    logic [1:0] fa, fb, mop;
    logic [31:0] a, b, w, imm, pc4, sa, fwb, exp;
    logic src;
    tv[0] = '{4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 32'd7, "add"};
    tv[1] = '{4'd1, 32'd3, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFE, "sub"};
    tv[2] = '{4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 32'h00F0_1200, "and"};
    tv[3] = '{4'd3, 32'hF000_0001, 32'h0000_0F00, 32'd0, 1'b0, 32'hF000_0F01, "or"};
    tv[4] = '{4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 1'b0, 32'hF0F0_0F0F, "xor"};
    tv[5] = '{4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1, "slt"};
    tv[6] = '{4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, "sltu"};
    tv[7] = '{4'd7, 32'd1, 32'h0000_003F, 32'd0, 1'b0, 32'h8000_0000, "sll"};
    tv[8] = '{4'd8, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 32'h0800_0000, "srl"};
    tv[9] = '{4'd9, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 32'hF800_0000, "sra"};
    tv[10] = '{4'd10, 32'd5, 32'd6, 32'd0, 1'b0, 32'd0, "op10"};
    tv[11] = '{4'd0, 32'd10, 32'd99, 32'h20, 1'b1, 32'h2A, "addi"};
    idle_in();
    bus.valid_e = 1'b1;
    bus.jump_e = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset busy_e", {31'd0, bus.busy_e}, 32'd0);
    chk("reset pc_src_e", {31'd0, bus.pc_src_e}, 32'd0);
    chk("reset valid_m", {31'd0, bus.valid_m}, 32'd0);
    chk("reset alu_result_m", bus.alu_result_m, 32'd0);
    tick();
    tick();
    idle_in();
    rst = 1'b1;
    prev_m = 32'd0;
    for (int i = 0; i < 12; i++) begin
      bus.valid_e = 1'b1;
      bus.reg_write_e = 1'b1;
      bus.alu_control_e = tv[i].op;
      bus.rd1_e = tv[i].a;
      bus.rd2_e = tv[i].b;
      bus.imm_ext_e = tv[i].imm;
      bus.alu_src_e = tv[i].src;
      tick();
      chk(tv[i].nm, bus.alu_result_m, tv[i].exp);
    end
    chk("table valid_m", {31'd0, bus.valid_m}, 32'd1);
    bus.alu_control_e = 4'd0;
    bus.alu_src_e = 1'b0;
    bus.rd1_e = 32'd2;
    bus.rd2_e = 32'd3;
    tick();
    chk("fwd setup add", bus.alu_result_m, 32'd5);
    bus.forward_a_e = 2'b10;
    bus.forward_b_e = 2'b01;
    bus.result_w = 32'd7;
    bus.rd1_e = 32'd100;
    bus.rd2_e = 32'd100;
    tick();
    chk("fwd add", bus.alu_result_m, 32'd12);
    chk("fwd valid_m", {31'd0, bus.valid_m}, 32'd1);
    idle_in();
    bus.valid_e = 1'b1;
    bus.branch_e = 1'b1;
    bus.rd1_e = 32'hFFFF_FFFF;
    bus.rd2_e = 32'd1;
    bus.pc_e = 32'h100;
    bus.imm_ext_e = 32'h20;
    bus.branch_op_e = 3'b100;
    #1;
    chk("blt pc_src", {31'd0, bus.pc_src_e}, 32'd1);
    chk("blt target", bus.pc_target_e, 32'h120);
    bus.branch_op_e = 3'b111;
    #1 chk("bgeu pc_src", {31'd0, bus.pc_src_e}, 32'd1);
    bus.branch_op_e = 3'b101;
    #1 chk("bge pc_src", {31'd0, bus.pc_src_e}, 32'd0);
    bus.branch_op_e = 3'b010;
    #1 chk("f3=010 pc_src", {31'd0, bus.pc_src_e}, 32'd0);
    bus.branch_op_e = 3'b000;
    bus.rd2_e = 32'hFFFF_FFFF;
    #1 chk("beq pc_src", {31'd0, bus.pc_src_e}, 32'd1);
    bus.valid_e = 1'b0;
    #1 chk("invalid beq pc_src", {31'd0, bus.pc_src_e}, 32'd0);
    bus.valid_e = 1'b1;
    bus.branch_e = 1'b0;
    bus.jalr_e = 1'b1;
    bus.rd1_e = 32'h203;
    bus.imm_ext_e = 32'd0;
    #1;
    chk("jalr pc_src", {31'd0, bus.pc_src_e}, 32'd1);
    chk("jalr target", bus.pc_target_e, 32'h202);
    idle_in();
    run_md("mul", 2'd0, 32'h10000, 32'h10000, 32'd0, 1'b0);
    run_md("mulhu", 2'd1, 32'h10000, 32'h10000, 32'd1, 1'b0);
    run_md("divu by 0", 2'd2, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_md("remu by 0", 2'd3, 32'd100, 32'd0, 32'd100, 1'b0);
    run_md("divu 100/7 latched", 2'd2, 32'd100, 32'd7, 32'd14, 1'b1);
    run_md("remu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (i % 6 == 5) begin
        mop = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom >> $urandom_range(0, 31);
        run_md($sformatf("rnd md%0d", i), mop, a, b, md_ref(mop, a, b), 1'b0);
      end else begin
        op = 4'($urandom_range(0, 15));
        fa = 2'($urandom_range(0, 3));
        fb = 2'($urandom_range(0, 3));
        src = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
        w = $urandom;
        imm = $urandom;
        pc4 = $urandom;
        sa = sel(fa, a, w, prev_m);
        fwb = sel(fb, b, w, prev_m);
        exp = alu_ref(op, sa, src ? imm : fwb);
        idle_in();
        bus.valid_e = 1'b1;
        bus.reg_write_e = 1'b1;
        bus.alu_control_e = op;
        bus.forward_a_e = fa;
        bus.forward_b_e = fb;
        bus.alu_src_e = src;
        bus.rd1_e = a;
        bus.rd2_e = b;
        bus.result_w = w;
        bus.imm_ext_e = imm;
        bus.pc_plus4_e = pc4;
        tick();
        chk($sformatf("rnd alu%0d op%0d", i, op), bus.alu_result_m, exp);
        chk($sformatf("rnd wdata%0d", i), bus.write_data_m, fwb);
        chk($sformatf("rnd pc4_%0d", i), bus.pc_plus4_m, pc4);
        prev_m = exp;
      end
    end
    @(negedge clk);
    idle_in();
    bus.reg_write_e = 1'b1;
    bus.mem_write_e = 1'b1;
    bus.md_e = 1'b1;
    bus.result_src_e = 2'd2;
    bus.rd1_e = 32'h55;
    bus.rd2_e = 32'h66;
    bus.pc_plus4_e = 32'h44;
    #1 chk("invalid md busy_e", {31'd0, bus.busy_e}, 32'd0);
    tick();
    chk("bubble reg_write_m", {31'd0, bus.reg_write_m}, 32'd0);
    chk("bubble mem_write_m", {31'd0, bus.mem_write_m}, 32'd0);
    chk("bubble valid_m", {31'd0, bus.valid_m}, 32'd0);
    chk("bubble result_src_m", {30'd0, bus.result_src_m}, 32'd0);
    @(negedge clk);
    idle_in();
    bus.valid_e = 1'b1;
    bus.md_e = 1'b1;
    bus.jump_e = 1'b1;
    bus.md_op_e = 2'd2;
    bus.rd1_e = 32'd100;
    bus.rd2_e = 32'd7;
    bus.rd_e = 5'd3;
    repeat (10) tick();
    chk("mid divu busy_e", {31'd0, bus.busy_e}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst busy_e", {31'd0, bus.busy_e}, 32'd0);
    chk("rst pc_src_e", {31'd0, bus.pc_src_e}, 32'd0);
    chk("rst valid_m", {31'd0, bus.valid_m}, 32'd0);
    chk("rst alu_result_m", bus.alu_result_m, 32'd0);
    chk("rst write_data_m", bus.write_data_m, 32'd0);
    chk("rst pc_plus4_m", bus.pc_plus4_m, 32'd0);
    chk("rst rd_m", {27'd0, bus.rd_m}, 32'd0);
    idle_in();
    tick();
    rst = 1'b1;
    bus.valid_e = 1'b1;
    bus.reg_write_e = 1'b1;
    bus.rd1_e = 32'd2;
    bus.rd2_e = 32'd3;
    tick();
    chk("post-rst add", bus.alu_result_m, 32'd5);
    chk("post-rst valid_m", {31'd0, bus.valid_m}, 32'd1);
    chk("post-rst busy_e", {31'd0, bus.busy_e}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
